id_issue_stage: RTL and testbench

//  Instruction decode and issue stage: the producer side of the ALU operand interface.

---
 rtl/mips_isa_pkg.sv | 58 +++++
 rtl/id_scoreboard.sv | 31 +++
 rtl/id_issue_stage.sv | 150 +++++++++++++++
 tb/tb_id_issue_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/func encodings, issue bundle type and immediate extenders
// shared by the decode/issue stage, ALU and control.
package mips_isa_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [5:0]  func;
      logic [4:0]  sa;
      logic [31:0] first;
      logic [31:0] second;
      logic [31:0] store;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } issue_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic logic [31:0] zext16(input logic [15:0] v);
      return {16'h0000, v};
   endfunction

   function automatic logic fn_known(input logic [5:0] fn);
      return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_ADD, FN_ADDU,
                        FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
   endfunction
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: pending-write vector with writeback clear, flush rollback and issue set;
// lookups see this cycle's clears so a retiring register unblocks immediately.
module id_scoreboard #(
   parameter int NREGS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_set_en,
   input  logic [4:0] i_set_addr,
   input  logic       i_clr_en,
   input  logic [4:0] i_clr_addr,
   input  logic       i_rb_en,
   input  logic [4:0] i_rb_addr,
   input  logic [4:0] i_rs_addr,
   input  logic [4:0] i_rt_addr,
   output logic       o_rs_pend,
   output logic       o_rt_pend
);
   logic [NREGS-1:0] r_pend, w_set, w_clr, w_vis;

   // r0 can never become pending
   assign w_set = (i_set_en ? NREGS'(1) << i_set_addr : '0) & ~NREGS'(1);
   assign w_clr = (i_clr_en ? NREGS'(1) << i_clr_addr : '0) | (i_rb_en ? NREGS'(1) << i_rb_addr : '0);
   assign w_vis = r_pend & ~w_clr;
   assign o_rs_pend = w_vis[i_rs_addr];
   assign o_rt_pend = w_vis[i_rt_addr];

   always_ff @(posedge clk or posedge rst)
      if (rst) r_pend <= '0;
      else     r_pend <= w_vis | w_set;
endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode, operand select and registered issue to EX with RAW stall.
// Define ILLEGAL_TRAP_EN to drop unknown words and raise sticky illegal_instr instead of issuing a NOP.
module id_issue_stage
   import mips_isa_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int LINK_REG = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic [4:0]  rf_rs_addr,
   output logic [4:0]  rf_rt_addr,
   input  logic [31:0] rf_rs_data,
   input  logic [31:0] rf_rt_data,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [5:0]  ex_opcode,
   output logic [5:0]  ex_func,
   output logic [4:0]  ex_sa,
   output logic [31:0] ex_first_val,
   output logic [31:0] ex_second_val,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   input  logic        ex_flush,
   input  logic        wb_valid,
   input  logic [4:0]  wb_dest,
   output logic        illegal_instr
);
   issue_t      r_ex, w_b;
   logic        r_ex_valid, w_legal, w_rs_use, w_rt_use, w_rs_pend, w_rt_pend;
   logic        w_advance, w_stall, w_xfer, w_issue;
   logic [5:0]  w_op, w_fn;
   logic [15:0] w_imm;

   assign w_op       = if_instr[31:26];
   assign w_fn       = if_instr[5:0];
   assign w_imm      = if_instr[15:0];
   assign rf_rs_addr = if_instr[25:21];
   assign rf_rt_addr = if_instr[20:16];

   always_comb begin
      w_b        = '0;
      w_b.opcode = w_op;
      w_b.func   = w_fn;
      w_b.sa     = if_instr[10:6];
      w_b.first  = rf_rs_data;
      w_b.second = rf_rt_data;
      w_legal    = 1'b0;
      w_rs_use   = 1'b0;
      w_rt_use   = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_legal  = fn_known(w_fn);
            w_rs_use = w_legal;
            w_rt_use = w_legal;
            w_b.dest = (w_legal && w_fn != FN_JR) ? if_instr[15:11] : 5'd0;
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_ANDI, OP_ORI, OP_XORI: begin
            w_legal      = 1'b1;
            w_rs_use     = 1'b1;
            w_b.second   = (w_op inside {OP_ANDI, OP_ORI, OP_XORI}) ? zext16(w_imm) : sext16(w_imm);
            w_b.dest     = if_instr[20:16];
            w_b.mem_read = (w_op == OP_LW);
         end
         OP_SW: begin
            w_legal       = 1'b1;
            w_rs_use      = 1'b1;
            w_rt_use      = 1'b1;
            w_b.second    = sext16(w_imm);
            w_b.store     = rf_rt_data;
            w_b.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_legal  = 1'b1;
            w_rs_use = 1'b1;
            w_rt_use = 1'b1;
         end
         OP_JAL: begin
            w_legal   = 1'b1;
            w_b.first = if_pc + 32'd4;
            w_b.dest  = 5'(LINK_REG);
         end
         default: ;
      endcase
      w_b.reg_write = w_legal && (w_b.dest != 5'd0);
   end

   assign w_advance = !r_ex_valid || ex_ready;
   assign w_stall   = (w_rs_use && w_rs_pend) || (w_rt_use && w_rt_pend);
   assign if_ready  = w_advance && !w_stall && !ex_flush;
   assign w_xfer    = if_valid && if_ready;

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;
   assign w_issue       = w_legal;
   assign illegal_instr = r_illegal;
   always_ff @(posedge clk or posedge rst)
      if (rst)                    r_illegal <= 1'b0;
      else if (w_xfer && !w_legal) r_illegal <= 1'b1;
`else
   assign w_issue       = 1'b1;
   assign illegal_instr = 1'b0;
`endif

   // flush beats both hold and issue; a killed writer releases its scoreboard bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_ex_valid <= 1'b0;
         r_ex       <= '0;
      end else if (ex_flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_advance) begin
         r_ex_valid <= w_xfer && w_issue;
         if (w_xfer && w_issue) r_ex <= w_b;
      end

   id_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .i_set_en  (w_xfer && w_issue && w_b.reg_write),
      .i_set_addr(w_b.dest),
      .i_clr_en  (wb_valid),
      .i_clr_addr(wb_dest),
      .i_rb_en   (ex_flush && r_ex_valid && r_ex.reg_write),
      .i_rb_addr (r_ex.dest),
      .i_rs_addr (rf_rs_addr),
      .i_rt_addr (rf_rt_addr),
      .o_rs_pend (w_rs_pend),
      .o_rt_pend (w_rt_pend)
   );

   assign ex_valid      = r_ex_valid;
   assign ex_opcode     = r_ex.opcode;
   assign ex_func       = r_ex.func;
   assign ex_sa         = r_ex.sa;
   assign ex_first_val  = r_ex.first;
   assign ex_second_val = r_ex.second;
   assign ex_store_data = r_ex.store;
   assign ex_dest       = r_ex.dest;
   assign ex_reg_write  = r_ex.reg_write;
   assign ex_mem_read   = r_ex.mem_read;
   assign ex_mem_write  = r_ex.mem_write;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: table-driven decode vectors plus hazard, hold, flush, illegal and reset sequences;
// expected bundles queue up at transfer and are compared when EX consumes them.
module tb_id_issue_stage;
   import mips_isa_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        if_valid = 1'b0, if_ready;
   logic [31:0] if_instr = '0, if_pc = '0;
   logic [4:0]  rf_rs_addr, rf_rt_addr;
   logic [31:0] rf_rs_data, rf_rt_data;
   logic        ex_valid, ex_ready = 1'b1, ex_flush = 1'b0;
   logic [5:0]  ex_opcode, ex_func;
   logic [4:0]  ex_sa, ex_dest;
   logic [31:0] ex_first_val, ex_second_val, ex_store_data;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_dest = '0;
   logic        illegal_instr;

   int n_tests = 0, n_fail = 0;
   issue_t q[$];

   typedef struct {
      logic [31:0] instr;
      issue_t      e;
   } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   id_issue_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_sa(ex_sa),
      .ex_first_val(ex_first_val), .ex_second_val(ex_second_val), .ex_store_data(ex_store_data),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_flush(ex_flush), .wb_valid(wb_valid), .wb_dest(wb_dest), .illegal_instr(illegal_instr)
   );

   function automatic logic [31:0] rv(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : {8'hA5, 3'b000, a, 8'h5A, 3'b000, a};
   endfunction

   assign rf_rs_data = rv(rf_rs_addr);
   assign rf_rt_data = rv(rf_rt_addr);

   function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int sa, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
   endfunction

   function automatic logic [31:0] i_i(input int op, input int rs, input int rt, input logic [15:0] imm);
      return {6'(op), 5'(rs), 5'(rt), imm};
   endfunction

   function automatic issue_t mk(input logic [31:0] i, input logic [31:0] f, input logic [31:0] s,
                                 input logic [31:0] st, input logic [4:0] d, input logic rw,
                                 input logic mr, input logic mw);
      return {i[31:26], i[5:0], i[10:6], f, s, st, d, rw, mr, mw};
   endfunction

   function automatic vec_t mv(input logic [31:0] i, input logic [31:0] f, input logic [31:0] s,
                               input logic [31:0] st, input logic [4:0] d, input logic rw,
                               input logic mr, input logic mw);
      vec_t v;
      v.instr = i;
      v.e     = mk(i, f, s, st, d, rw, mr, mw);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input issue_t e, input bit push);
      int n = 0;
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      @(negedge clk);
      while (!if_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("accept_%h", instr), 32'(if_ready), 32'd1);
      if (if_ready && push) q.push_back(e);
      @(posedge clk);
      #1 if_valid = 1'b0;
   endtask

   task automatic retire(input logic [4:0] r);
      wb_valid = 1'b1;
      wb_dest  = r;
      @(posedge clk);
      #1 wb_valid = 1'b0;
   endtask

   // reader must stay blocked n cycles, then issue in the same cycle its source retires
   task automatic release_after(input logic [31:0] instr, input issue_t e, input logic [4:0] r, input int n);
      if_valid = 1'b1;
      if_instr = instr;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("raw_stall", 32'(if_ready), 32'd0);
      end
      wb_valid = 1'b1;
      wb_dest  = r;
      #1 chk("raw_release", 32'(if_ready), 32'd1);
      if (if_ready) q.push_back(e);
      @(posedge clk);
      #1 wb_valid = 1'b0;
      if_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      issue_t a, e;
      if (!rst && ex_valid && ex_ready && !ex_flush) begin
         a = {ex_opcode, ex_func, ex_sa, ex_first_val, ex_second_val, ex_store_data,
              ex_dest, ex_reg_write, ex_mem_read, ex_mem_write};
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL bundle_unexpected: got %h expected none", a);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display("FAIL bundle: got %h expected %h", a, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = mv(32'h2001FFFB, 0, 32'hFFFFFFFB, 0, 1, 1, 0, 0);
      tbl[1]  = mv(i_i(13, 0, 2, 16'h8001), 0, 32'h00008001, 0, 2, 1, 0, 0);
      tbl[2]  = mv(i_i(14, 1, 5, 16'hF0F0), rv(1), 32'h0000F0F0, 0, 5, 1, 0, 0);
      tbl[3]  = mv(i_i(12, 2, 6, 16'hFFFF), rv(2), 32'h0000FFFF, 0, 6, 1, 0, 0);
      tbl[4]  = mv(i_i(9, 3, 7, 16'h8000), rv(3), 32'hFFFF8000, 0, 7, 1, 0, 0);
      tbl[5]  = mv(i_i(35, 9, 8, 16'hFFFC), rv(9), 32'hFFFFFFFC, 0, 8, 1, 1, 0);
      tbl[6]  = mv(i_i(43, 11, 10, 16'h0010), rv(11), 32'h00000010, rv(10), 0, 0, 0, 1);
      tbl[7]  = mv(r_i(13, 14, 12, 0, 32), rv(13), rv(14), 0, 12, 1, 0, 0);
      tbl[8]  = mv(r_i(1, 2, 0, 0, 34), rv(1), rv(2), 0, 0, 0, 0, 0);
      tbl[9]  = mv(r_i(31, 0, 0, 0, 8), rv(31), 0, 0, 0, 0, 0, 0);
      tbl[10] = mv(i_i(4, 1, 2, 16'h0003), rv(1), rv(2), 0, 0, 0, 0, 0);
      tbl[11] = mv(r_i(0, 4, 3, 5, 0), 0, rv(4), 0, 3, 1, 0, 0);
      tbl[12] = mv(i_i(8, 1, 0, 16'h0007), rv(1), 32'h00000007, 0, 0, 0, 0, 0);

      #3;
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_ex_first", ex_first_val, 0);
      chk("rst_ex_dest", 32'(ex_dest), 0);
      chk("rst_reg_write", 32'(ex_reg_write), 0);
      chk("rst_illegal", 32'(illegal_instr), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_if_ready", 32'(if_ready), 1);

      for (int i = 0; i < 13; i++) begin
         send(tbl[i].instr, 32'h1000 + 32'(4 * i), tbl[i].e, 1'b1);
         if (tbl[i].e.reg_write) retire(tbl[i].e.dest);
      end

      // lw r3 then add r4,r3,r3
      send(i_i(35, 0, 3, 16'h0000), 0, mk(i_i(35, 0, 3, 16'h0000), 0, 0, 0, 3, 1, 1, 0), 1'b1);
      release_after(r_i(3, 3, 4, 0, 32), mk(r_i(3, 3, 4, 0, 32), rv(3), rv(3), 0, 4, 1, 0, 0), 5'd3, 3);
      retire(4);

      // issue-set of r9 collides with its own writeback clear: set must win
      wb_valid = 1'b1;
      wb_dest  = 5'd9;
      send(i_i(8, 0, 9, 16'h0001), 0, mk(i_i(8, 0, 9, 16'h0001), 0, 1, 0, 9, 1, 0, 0), 1'b1);
      wb_valid = 1'b0;
      release_after(r_i(9, 0, 10, 0, 32), mk(r_i(9, 0, 10, 0, 32), rv(9), 0, 0, 10, 1, 0, 0), 5'd9, 2);
      retire(10);

      // backpressure hold
      ex_ready = 1'b0;
      send(i_i(13, 0, 20, 16'h1234), 0, mk(i_i(13, 0, 20, 16'h1234), 0, 32'h1234, 0, 20, 1, 0, 0), 1'b1);
      if_valid = 1'b1;
      if_instr = i_i(8, 0, 21, 16'h0055);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_if_ready", 32'(if_ready), 0);
         chk("hold_ex_valid", 32'(ex_valid), 1);
         chk("hold_second", ex_second_val, 32'h1234);
         chk("hold_dest", 32'(ex_dest), 20);
      end
      @(posedge clk);
      #1 ex_ready = 1'b1;
      send(i_i(8, 0, 21, 16'h0055), 0, mk(i_i(8, 0, 21, 16'h0055), 0, 32'h55, 0, 21, 1, 0, 0), 1'b1);
      retire(20);
      retire(21);
      chk("hold_no_loss_dup", 32'(q.size()), 0);

      // jal then flush
      ex_ready = 1'b0;
      send({6'd3, 26'h0000010}, 32'h40, '0, 1'b0);
      chk("jal_valid", 32'(ex_valid), 1);
      chk("jal_first", ex_first_val, 32'h44);
      chk("jal_dest", 32'(ex_dest), 31);
      chk("jal_reg_write", 32'(ex_reg_write), 1);
      ex_flush = 1'b1;
      if_valid = 1'b1;
      if_instr = i_i(8, 0, 6, 16'h0001);
      #1 chk("flush_if_ready", 32'(if_ready), 0);
      @(posedge clk);
      #1 ex_flush = 1'b0;
      chk("flush_kill", 32'(ex_valid), 0);
      if_instr = r_i(31, 0, 5, 0, 32);
      #1 chk("flush_rollback_r31", 32'(if_ready), 1);
      ex_ready = 1'b1;
      send(r_i(31, 0, 5, 0, 32), 0, mk(r_i(31, 0, 5, 0, 32), rv(31), 0, 0, 5, 1, 0, 0), 1'b1);
      retire(5);

      // unknown opcode
      ex_ready = 1'b0;
      send(32'hFC000000, 0, '0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      chk("illegal_not_issued", 32'(ex_valid), 0);
      chk("illegal_flag", 32'(illegal_instr), 1);
      @(negedge clk);
      chk("illegal_sticky", 32'(illegal_instr), 1);
`else
      chk("nop_issued", 32'(ex_valid), 1);
      chk("nop_opcode", 32'(ex_opcode), 32'h3F);
      chk("nop_reg_write", 32'(ex_reg_write), 0);
      chk("nop_mem", {30'd0, ex_mem_read, ex_mem_write}, 0);
      chk("nop_illegal_low", 32'(illegal_instr), 0);
`endif
      ex_flush = 1'b1;
      @(posedge clk);
      #1 ex_flush = 1'b0;

      // async reset during a hold with r22 pending
      send(i_i(13, 0, 22, 16'h0077), 0, '0, 1'b0);
      chk("pre_rst_valid", 32'(ex_valid), 1);
      #2 rst = 1'b1;
      #1 chk("async_rst_valid", 32'(ex_valid), 0);
      chk("async_rst_second", ex_second_val, 0);
      chk("async_rst_illegal", 32'(illegal_instr), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      if_valid = 1'b1;
      if_instr = r_i(22, 0, 23, 0, 32);
      #1 chk("rst_clears_pending", 32'(if_ready), 1);
      if_valid = 1'b0;
      ex_ready = 1'b1;

      @(negedge clk);
      chk("scoreboard_drain", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
